// File: rtl/video_pkg.sv
// Shared definitions for the collision block: object indices, CPU register
// indices and the table of the 15 object pairs watched for overlap.
package video_pkg;

    localparam int NUM_OBJS  = 6;
    localparam int NUM_PAIRS = 15;

    typedef enum logic [2:0] {
        OBJ_P0 = 3'd0,
        OBJ_P1 = 3'd1,
        OBJ_M0 = 3'd2,
        OBJ_M1 = 3'd3,
        OBJ_BL = 3'd4,
        OBJ_PF = 3'd5
    } obj_e;

    typedef enum logic [2:0] {
        CX_M0P  = 3'd0,
        CX_M1P  = 3'd1,
        CX_P0FB = 3'd2,
        CX_P1FB = 3'd3,
        CX_M0FB = 3'd4,
        CX_M1FB = 3'd5,
        CX_BLPF = 3'd6,
        CX_PPMM = 3'd7
    } cx_reg_e;

    typedef struct packed {
        obj_e a;
        obj_e b;
    } pair_t;

    // Pairs 2r and 2r+1 land in bit7/bit6 of register r for r=0..5; the
    // tail (BL-PF, P0-P1, M0-M1) is packed by cx_pack below.
    localparam pair_t PAIR_TABLE [NUM_PAIRS] = '{
        '{OBJ_M0, OBJ_P1}, '{OBJ_M0, OBJ_P0},
        '{OBJ_M1, OBJ_P0}, '{OBJ_M1, OBJ_P1},
        '{OBJ_P0, OBJ_PF}, '{OBJ_P0, OBJ_BL},
        '{OBJ_P1, OBJ_PF}, '{OBJ_P1, OBJ_BL},
        '{OBJ_M0, OBJ_PF}, '{OBJ_M0, OBJ_BL},
        '{OBJ_M1, OBJ_PF}, '{OBJ_M1, OBJ_BL},
        '{OBJ_BL, OBJ_PF},
        '{OBJ_P0, OBJ_P1}, '{OBJ_M0, OBJ_M1}
    };

    function automatic logic [7:0] cx_pack(input logic [NUM_PAIRS-1:0] flags,
                                           input cx_reg_e          reg_sel);
        case (reg_sel)
            CX_BLPF: return {flags[12], 7'b0};
            CX_PPMM: return {flags[13], flags[14], 6'b0};
            default: return {flags[{reg_sel, 1'b0}], flags[{reg_sel, 1'b1}], 6'b0};
        endcase
    endfunction

endpackage

// File: rtl/collision_latch.sv
// One sticky collision flag: live latch with set/clear plus a frame snapshot
// copy of the live value.
module collision_latch (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_set,
    input  logic i_clear,
    input  logic i_snap,
    output logic o_live,
    output logic o_snap
);

    logic r_live;
    logic r_snap;

    // NOTE: state is updated with non-blocking assignments so every latch
    // samples the pre-edge value of r_live, which the snapshot relies on.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_live <= 1'b0;
            r_snap <= 1'b0;
        end else begin
            // A hit in the clearing cycle survives; everything else drops.
            r_live <= i_clear ? i_set : (r_live | i_set);
            if (i_snap) r_snap <= r_live;
        end
    end

    assign o_live = r_live;
    assign o_snap = r_snap;

endmodule

// File: rtl/collision_detect.sv
// Atari 2600-style pairwise collision latches with a per-frame snapshot and
// a registered CPU read port.
module collision_detect
    import video_pkg::*;
#(
    parameter int NUM_REGS   = 8,
    parameter bit AUTO_CLEAR = 1'b0
) (
    input  logic       raw_clk,
    input  logic       reset_n,
    input  logic       pixel_strobe,
    input  logic       in_image,
    input  logic       in_vblank,
    input  logic       player_0_value,
    input  logic       player_1_value,
    input  logic       missile_0_value,
    input  logic       missile_1_value,
    input  logic       ball_value,
    input  logic       playfield_value,
    input  logic       clear,
    input  logic       read_enable,
    input  logic [2:0] address,
    output logic [7:0] data_out,
    output logic       frame_done,
    output logic       any_collision
);

    logic [NUM_OBJS-1:0]  w_obj;
    logic [NUM_PAIRS-1:0] w_live;
    logic [NUM_PAIRS-1:0] w_snap_bits;
    logic                 w_sample;
    logic                 w_snap;
    logic                 w_latch_clr;

    logic       r_vblank_d;
    logic       r_frame_done;
    logic [7:0] r_data_out;

    always_comb begin
        w_obj         = '0;
        w_obj[OBJ_P0] = player_0_value;
        w_obj[OBJ_P1] = player_1_value;
        w_obj[OBJ_M0] = missile_0_value;
        w_obj[OBJ_M1] = missile_1_value;
        w_obj[OBJ_BL] = ball_value;
        w_obj[OBJ_PF] = playfield_value;
    end

    assign w_sample    = pixel_strobe & in_image;
    assign w_snap      = in_vblank & ~r_vblank_d;
    assign w_latch_clr = clear | (AUTO_CLEAR & w_snap);

    for (genvar g = 0; g < NUM_PAIRS; g++) begin : g_pair
        collision_latch u_latch (
            .i_clk   (raw_clk),
            .i_rst_n (reset_n),
            .i_set   (w_sample & w_obj[PAIR_TABLE[g].a] & w_obj[PAIR_TABLE[g].b]),
            .i_clear (w_latch_clr),
            .i_snap  (w_snap),
            .o_live  (w_live[g]),
            .o_snap  (w_snap_bits[g])
        );
    end

    always_ff @(posedge raw_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vblank_d   <= 1'b0;
            r_frame_done <= 1'b0;
            r_data_out   <= 8'h00;
        end else begin
            r_vblank_d   <= in_vblank;
            r_frame_done <= w_snap;
            if (read_enable) begin
                r_data_out <= (int'(address) < NUM_REGS)
                            ? cx_pack(w_snap_bits, cx_reg_e'(address)) : 8'h00;
            end
        end
    end

    assign data_out      = r_data_out;
    assign frame_done    = r_frame_done;
    assign any_collision = |w_live;

endmodule

// File: tb/tb_collision_detect.sv
// Scoreboard bench for collision_detect: one instance with AUTO_CLEAR=0 and
// one with AUTO_CLEAR=1 share the same stimulus.
module tb_collision_detect;
    import video_pkg::*;

    logic       raw_clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       pixel_strobe = 1'b0, in_image = 1'b0, in_vblank = 1'b0;
    logic       player_0_value = 1'b0, player_1_value = 1'b0;
    logic       missile_0_value = 1'b0, missile_1_value = 1'b0;
    logic       ball_value = 1'b0, playfield_value = 1'b0;
    logic       clear = 1'b0, read_enable = 1'b0;
    logic [2:0] address = 3'd0;
    logic [7:0] data_out, data_out_ac;
    logic       frame_done, frame_done_ac, any_collision, any_collision_ac;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string      name;
        bit         ac;
        logic [7:0] exp;
    } rd_t;
    rd_t sb[$];

    always #5 raw_clk = ~raw_clk;

    collision_detect #(.NUM_REGS(8), .AUTO_CLEAR(1'b0)) dut (
        .raw_clk(raw_clk), .reset_n(reset_n), .pixel_strobe(pixel_strobe),
        .in_image(in_image), .in_vblank(in_vblank),
        .player_0_value(player_0_value), .player_1_value(player_1_value),
        .missile_0_value(missile_0_value), .missile_1_value(missile_1_value),
        .ball_value(ball_value), .playfield_value(playfield_value),
        .clear(clear), .read_enable(read_enable), .address(address),
        .data_out(data_out), .frame_done(frame_done), .any_collision(any_collision)
    );

    collision_detect #(.NUM_REGS(8), .AUTO_CLEAR(1'b1)) dut_ac (
        .raw_clk(raw_clk), .reset_n(reset_n), .pixel_strobe(pixel_strobe),
        .in_image(in_image), .in_vblank(in_vblank),
        .player_0_value(player_0_value), .player_1_value(player_1_value),
        .missile_0_value(missile_0_value), .missile_1_value(missile_1_value),
        .ball_value(ball_value), .playfield_value(playfield_value),
        .clear(clear), .read_enable(read_enable), .address(address),
        .data_out(data_out_ac), .frame_done(frame_done_ac),
        .any_collision(any_collision_ac)
    );

    // Read monitor: each accepted read pops one expectation, checked just
    // after the edge that loads data_out.
    always @(posedge raw_clk) begin
        rd_t        e;
        logic [7:0] got;
        if (read_enable) begin
            #1;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL rd_unexpected: read with empty scoreboard");
            end else begin
                e   = sb.pop_front();
                got = e.ac ? data_out_ac : data_out;
                if (got !== e.exp) begin
                    failures++;
                    $display("FAIL %s: data_out=0x%02h expected 0x%02h", e.name, got, e.exp);
                end
            end
        end
    end

    task automatic set_objs(input logic [5:0] m);
        player_0_value  = m[OBJ_P0];
        player_1_value  = m[OBJ_P1];
        missile_0_value = m[OBJ_M0];
        missile_1_value = m[OBJ_M1];
        ball_value      = m[OBJ_BL];
        playfield_value = m[OBJ_PF];
    endtask

    function automatic logic [5:0] om(input obj_e a, input obj_e b);
        logic [5:0] m = '0;
        m[a] = 1'b1;
        m[b] = 1'b1;
        return m;
    endfunction

    task automatic pixel(input logic [5:0] m, input logic img);
        set_objs(m);
        pixel_strobe = 1'b1;
        in_image     = img;
        @(negedge raw_clk);
        pixel_strobe = 1'b0;
        in_image     = 1'b0;
        set_objs('0);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge raw_clk);
        clear = 1'b0;
    endtask

    task automatic vblank(input string name);
        int fd  = 0;
        int fda = 0;
        in_vblank = 1'b1;
        repeat (4) begin
            @(negedge raw_clk);
            if (frame_done === 1'b1) fd++;
            if (frame_done_ac === 1'b1) fda++;
        end
        in_vblank = 1'b0;
        @(negedge raw_clk);
        checks++;
        if (fd != 1) begin
            failures++;
            $display("FAIL %s_frame_done: pulses=%0d expected 1", name, fd);
        end
        checks++;
        if (fda != 1) begin
            failures++;
            $display("FAIL %s_frame_done_ac: pulses=%0d expected 1", name, fda);
        end
    endtask

    task automatic rd(input string name, input bit ac, input logic [2:0] a,
                      input logic [7:0] exp);
        rd_t e;
        e.name = name;
        e.ac   = ac;
        e.exp  = exp;
        sb.push_back(e);
        address     = a;
        read_enable = 1'b1;
        @(negedge raw_clk);
        read_enable = 1'b0;
    endtask

    task automatic test_reset();
        set_objs(6'h3f);
        pixel_strobe = 1'b1;
        in_image     = 1'b1;
        repeat (2) @(negedge raw_clk);
        checks++;
        if (any_collision !== 1'b1) begin
            failures++;
            $display("FAIL reset_pre_any: any_collision=%b expected 1", any_collision);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (any_collision !== 1'b0 || frame_done !== 1'b0 || data_out !== 8'h00) begin
            failures++;
            $display("FAIL reset_async: any=%b fd=%b data=0x%02h expected 0/0/0x00",
                     any_collision, frame_done, data_out);
        end
        @(negedge raw_clk);
        set_objs('0);
        pixel_strobe = 1'b0;
        in_image     = 1'b0;
        reset_n      = 1'b1;
        @(negedge raw_clk);
        vblank("reset");
        for (int i = 0; i < 8; i++) rd($sformatf("reset_addr%0d", i), 1'b0, 3'(i), 8'h00);
        checks++;
        if (any_collision !== 1'b0 || any_collision_ac !== 1'b0) begin
            failures++;
            $display("FAIL reset_post_any: any=%b any_ac=%b expected 0/0",
                     any_collision, any_collision_ac);
        end
    endtask

    task automatic test_p0_pf();
        do_clear();
        pixel(om(OBJ_P0, OBJ_PF), 1'b1);
        vblank("p0pf");
        for (int i = 0; i < 8; i++)
            rd($sformatf("p0pf_addr%0d", i), 1'b0, 3'(i), (i == 2) ? 8'h80 : 8'h00);
    endtask

    task automatic test_outside_image();
        do_clear();
        pixel(om(OBJ_M0, OBJ_M1), 1'b0);
        checks++;
        if (any_collision !== 1'b0) begin
            failures++;
            $display("FAIL outside_any: any_collision=%b expected 0", any_collision);
        end
        vblank("outside");
        rd("outside_addr7", 1'b0, 3'd7, 8'h00);
    endtask

    task automatic test_clear_race();
        do_clear();
        pixel(om(OBJ_M0, OBJ_P1), 1'b1);
        set_objs(om(OBJ_M1, OBJ_P0));
        pixel_strobe = 1'b1;
        in_image     = 1'b1;
        clear        = 1'b1;
        @(negedge raw_clk);
        pixel_strobe = 1'b0;
        in_image     = 1'b0;
        clear        = 1'b0;
        set_objs('0);
        checks++;
        if (any_collision !== 1'b1) begin
            failures++;
            $display("FAIL race_any: any_collision=%b expected 1", any_collision);
        end
        vblank("race");
        rd("race_addr1", 1'b0, 3'd1, 8'h80);
        rd("race_addr0", 1'b0, 3'd0, 8'h00);
    endtask

    task automatic test_auto_clear();
        do_clear();
        pixel(om(OBJ_BL, OBJ_PF), 1'b1);
        vblank("ac_n");
        rd("ac_frame_n", 1'b1, 3'd6, 8'h80);
        checks++;
        if (any_collision_ac !== 1'b0 || any_collision !== 1'b1) begin
            failures++;
            $display("FAIL ac_live: any_ac=%b any=%b expected 0/1",
                     any_collision_ac, any_collision);
        end
        vblank("ac_n1");
        rd("ac_frame_n1", 1'b1, 3'd6, 8'h00);
        rd("noac_frame_n1", 1'b0, 3'd6, 8'h80);
    endtask

    task automatic test_read_latency();
        do_clear();
        pixel(om(OBJ_P0, OBJ_P1), 1'b1);
        pixel(om(OBJ_M0, OBJ_M1), 1'b1);
        vblank("lat");
        rd("lat_addr0", 1'b0, 3'd0, 8'h00);
        rd("lat_addr7", 1'b0, 3'd7, 8'hc0);
        address = 3'd2;
        repeat (2) @(negedge raw_clk);
        checks++;
        if (data_out !== 8'hc0) begin
            failures++;
            $display("FAIL lat_hold: data_out=0x%02h expected 0xc0", data_out);
        end
    endtask

    task automatic test_pre_edge();
        // data_out must not change before the edge that accepts the read.
        rd("pre_addr0", 1'b0, 3'd0, 8'h00);
        address     = 3'd7;
        read_enable = 1'b1;
        #1;
        checks++;
        if (data_out !== 8'h00) begin
            failures++;
            $display("FAIL pre_edge: data_out=0x%02h expected 0x00", data_out);
        end
        sb.push_back('{name: "pre_addr7", ac: 1'b0, exp: 8'hc0});
        @(negedge raw_clk);
        read_enable = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge raw_clk);
        reset_n = 1'b1;
        @(negedge raw_clk);
        test_reset();
        test_p0_pf();
        test_outside_image();
        test_clear_race();
        test_auto_clear();
        test_read_latency();
        test_pre_edge();
        repeat (10) begin
            if (sb.size() != 0) @(negedge raw_clk);
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: pending=%0d expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/collision_detect.md
Name: collision_detect

Overview:
- Sits directly downstream of the peripherals video mixer.
- Samples the six per-pixel object values (player 0/1, missile 0/1, ball, playfield) on every visible pixel and latches Atari 2600-style pairwise collision flags.
- Exposes the flags to the CPU as eight read-only registers, plus a clear strobe and a per-frame snapshot.
- The peripherals block maps the read window and routes the clear write to this block.

Parameters:
- NUM_REGS, 8, number of readable collision registers (address[2:0]).
- AUTO_CLEAR, 0, when 1 live latches clear automatically at each snapshot.

Ports:
- raw_clk  input  1  system clock; all logic in this domain.
- reset_n  input  1  asynchronous active-low reset.
- pixel_strobe  input  1  one raw_clk pulse per displayed pixel, aligned with the object values below.
- in_image  input  1  high while inside the visible image.
- in_vblank  input  1  vertical blank indicator from the hdmi block.
- player_0_value  input  1  player 0 pixel on.
- player_1_value  input  1  player 1 pixel on.
- missile_0_value  input  1  missile 0 pixel on.
- missile_1_value  input  1  missile 1 pixel on.
- ball_value  input  1  ball pixel on.
- playfield_value  input  1  playfield pixel on.
- clear  input  1  one-cycle strobe (CPU write to CXCLR); clears live latches.
- read_enable  input  1  CPU read of the collision window.
- address  input  3  register select.
- data_out  output  8  read data; collision bits in [7:6], [5:0] read 0.
- frame_done  output  1  one-cycle pulse when a snapshot is taken.
- any_collision  output  1  OR of all 15 live latches.

Behaviour:
- Reset (async, reset_n low): all 15 live latches, all 15 snapshot bits, data_out, frame_done and the in_vblank edge register go to 0. Release is taken synchronously on the next raw_clk edge.
- Sample condition: pixel_strobe && in_image. Outside this condition the latches hold.
  - On a sample, each pair flag sets if both of its objects are 1.
  - Flags are sticky (set only) until cleared.
- Pairs and register map (bit7, bit6):
  - 0 CXM0P: M0-P1, M0-P0
  - 1 CXM1P: M1-P0, M1-P1
  - 2 CXP0FB: P0-PF, P0-BL
  - 3 CXP1FB: P1-PF, P1-BL
  - 4 CXM0FB: M0-PF, M0-BL
  - 5 CXM1FB: M1-PF, M1-BL
  - 6 CXBLPF: BL-PF, 0
  - 7 CXPPMM: P0-P1, M0-M1
- clear: all live latches go to 0 on the next edge.
  - Clear and a sample in the same cycle: the sampled set wins for the pairs hit in that cycle; all other pairs clear.
  - The snapshot is not affected by clear.
- Snapshot: detected on the in_vblank rising edge (registered compare of in_vblank against its previous value).
  - On that edge, live latches are copied to the snapshot, and frame_done pulses high for exactly one cycle on the following edge.
  - If AUTO_CLEAR=1, live latches clear in the same cycle as the copy. A sample in that cycle is ORed into the new live value, not lost.
  - A clear in the snapshot cycle does not block the copy; the copy uses the pre-clear value.
- Read:
  - data_out is registered: it updates one cycle after read_enable is high and reflects the snapshot register selected by address.
  - When read_enable is low, data_out holds its last value.
  - Reads have no side effects.
- any_collision is a combinational OR of the live latches.
- Mid-frame reset: all state zeroed; the next snapshot reflects only post-reset samples.

Decomposition:
- Shared package (video_pkg): register index constants CX_M0P..CX_PPMM, object bit indices (OBJ_P0=0, OBJ_P1, OBJ_M0, OBJ_M1, OBJ_BL, OBJ_PF), and the 15-entry pair table.
- One natural sub-module, collision_latch: a single sticky flag with set/clear/snapshot logic, instantiated 15 times.
- The register mux stays in the top module.

Test Plan:
- Reset: hold reset_n low mid-frame with all values=1, then release. Read addresses 0-7 -> data_out=0x00 for every address; frame_done and any_collision stay 0.
- P0+PF overlap: one pixel_strobe with in_image=1 and player_0_value=playfield_value=1, then one in_vblank rise, then read address 2 -> data_out=0x80 and frame_done pulses once. Every other address reads 0x00.
- Outside image: M0+M1 both 1 with pixel_strobe=1 and in_image=0, then vblank, then read address 7 -> data_out=0x00.
- Clear race: live M0-P1 is set; clear asserted in the same cycle as a sample with M1-P0=1. Next vblank, read address 1 -> 0x80; address 0 -> 0x00.
- AUTO_CLEAR=1: BL-PF hit in frame N and no hits in frame N+1. Read address 6 after vblank N -> 0x80; after vblank N+1 -> 0x00.
- Read latency: address=7, read_enable pulsed 1 cycle after P0-P1 and M0-M1 hits plus a snapshot -> data_out=0xC0 exactly one cycle later, holding after read_enable drops.
